stack_access_ctrl: RTL and testbench

- Initiator-side sequencer for the 256x8 data memory port: converts push/pop/call/return requests into memory address, write-enable and write-data cycles.
- Maintains the stack pointer, depth and full/empty status.
- Returns popped data, or the return address for RET, to the control unit over a valid/ready response channel.
- Sits between the processor control unit and the data memory, and replaces ad-hoc SP/NPC mux select driving.

---
 rtl/stack_access_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_stack_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_access_ctrl.sv
// ---------------------------------------------------------------------------
// stack_access_ctrl
//
// Initiator-side sequencer for the 256x8 data memory port. Turns PUSH, POP,
// CALL and RET requests from the control unit into single memory cycles. It
// also keeps the stack pointer, the depth count and the full/empty flags. The
// popped byte, or the return address for RET, is handed back over a
// valid/ready response channel.
//
// The stack grows downward. SP always points at the next free location, so a
// write uses SP and a read uses SP+1.
//
// Optional feature (compile-time macro STACK_GUARD_EN):
//   When it is defined, PUSH/CALL on a full stack and POP/RET on an empty
//   stack are suppressed. No write is made, SP and depth stay unchanged, and
//   the response is flagged with rsp_fault=1 and rsp_data=0.
//   When it is undefined, no check is made: SP wraps, depth saturates, and
//   rsp_fault is tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op                00 PUSH, 01 POP, 10 CALL, 11 RET
//   push_data             operand written by PUSH
//   npc_in                next-PC written by CALL
//   sp_load, sp_load_val  reload SP (and clear depth) while idle
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              popped byte, 0 for PUSH/CALL
//   rsp_is_ret            response belongs to a RET
//   rsp_fault             operation was suppressed by the guard
//   mem_addr, mem_wr,
//   mem_wdata, mem_rdata  data memory port (combinational read)
//   sp_out                current stack pointer
//   stack_empty/full      depth == 0 / depth == STACK_SIZE
// ---------------------------------------------------------------------------
module stack_access_ctrl #(
    parameter logic [7:0] SP_INIT    = 8'hFF,
    parameter int         STACK_SIZE = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] push_data,
    input  logic [7:0] npc_in,
    input  logic       sp_load,
    input  logic [7:0] sp_load_val,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_is_ret,
    output logic       rsp_fault,
    output logic [7:0] mem_addr,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp_out,
    output logic       stack_empty,
    output logic       stack_full
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [8:0] FULL_DEPTH = 9'(STACK_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] sp;
    logic [8:0] depth;
    logic [1:0] op_q;
    logic [7:0] operand_q;
    logic [7:0] rsp_data_q;
    logic       rsp_is_ret_q;
    logic       rsp_fault_q;

    logic       push_like;
    logic       fault;
    logic       accept;

    // PUSH and CALL both write downward. POP and RET both read upward.
    assign push_like = (op_q == OP_PUSH) || (op_q == OP_CALL);

    assign stack_empty = (depth == 9'd0);
    assign stack_full  = (depth == FULL_DEPTH);

    assign req_ready = (state == IDLE) && !sp_load;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_is_ret = rsp_is_ret_q;
    assign sp_out    = sp;

`ifdef STACK_GUARD_EN
    // The guard is only evaluated during EXEC, the cycle that would touch memory.
    assign fault     = (state == EXEC) && (push_like ? stack_full : stack_empty);
    assign rsp_fault = rsp_fault_q;
`else
    assign fault     = 1'b0;
    assign rsp_fault = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and memory port drive. EXEC always lasts exactly one
    // cycle. RESP waits for the consumer's handshake.
    always_comb begin
        state_next = state;
        mem_addr   = sp;
        mem_wr     = 1'b0;
        mem_wdata  = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
                if (push_like) begin
                    mem_addr  = sp;
                    mem_wdata = operand_q;
                    mem_wr    = !fault;
                end else begin
                    mem_addr = sp + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture. The operand is picked by opcode at accept time, so EXEC
    // only needs one data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_PUSH;
            operand_q <= 8'h00;
        end else if (accept) begin
            op_q      <= req_op;
            operand_q <= (req_op == OP_CALL) ? npc_in : push_data;
        end
    end

    // Stack pointer and depth. An sp_load in IDLE starts a fresh, empty stack.
    // Depth saturates at both ends; SP itself simply wraps modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= SP_INIT;
            depth <= 9'd0;
        end else if ((state == IDLE) && sp_load) begin
            sp    <= sp_load_val;
            depth <= 9'd0;
        end else if ((state == EXEC) && !fault) begin
            if (push_like) begin
                sp <= sp - 8'd1;
                if (depth != FULL_DEPTH) begin
                    depth <= depth + 9'd1;
                end
            end else begin
                sp <= sp + 8'd1;
                if (depth != 9'd0) begin
                    depth <= depth - 9'd1;
                end
            end
        end
    end

    // Response registers. They are loaded once at the end of EXEC and then
    // hold steady through RESP, for however long the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q   <= 8'h00;
            rsp_is_ret_q <= 1'b0;
            rsp_fault_q  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_q   <= (push_like || fault) ? 8'h00 : mem_rdata;
            rsp_is_ret_q <= (op_q == OP_RET);
            rsp_fault_q  <= fault;
        end
    end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_access_ctrl
//
// Directed and random bench for stack_access_ctrl, built with STACK_SIZE=4 so
// the full and empty boundaries are reached quickly. The bench owns a simple
// data memory. A reference model tracks a plain SP integer, a saturating depth
// count and an image of memory contents, and predicts every response.
// ---------------------------------------------------------------------------
module tb_stack_access_ctrl;

    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] push_data;
    logic [7:0] npc_in;
    logic       sp_load;
    logic [7:0] sp_load_val;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_is_ret;
    logic       rsp_fault;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] sp_out;
    logic       stack_empty;
    logic       stack_full;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int         m_sp;
    int         m_depth;
    logic [7:0] m_mem [256];
    bit         guard_on;

    // Data memory seen by the DUT.
    logic [7:0] dmem [256];

    stack_access_ctrl #(.SP_INIT(8'hFF), .STACK_SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .push_data(push_data), .npc_in(npc_in),
        .sp_load(sp_load), .sp_load_val(sp_load_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_is_ret(rsp_is_ret), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .sp_out(sp_out), .stack_empty(stack_empty), .stack_full(stack_full)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) dmem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag);
        check({tag, " sp_out"}, 32'(sp_out), 32'(m_sp));
        check({tag, " empty"}, 32'(stack_empty), 32'(m_depth == 0));
        check({tag, " full"}, 32'(stack_full), 32'(m_depth == SIZE));
    endtask

    // Issue one operation and follow it through EXEC and RESP. The response
    // is held back for 'hold' cycles before it is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data, input int hold);
        bit         push_like;
        bit         fault;
        logic [7:0] exp_data;
        logic [7:0] exp_addr;
        int         waited;
        push_like = (op == 2'b00) || (op == 2'b10);
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        push_data = (op == 2'b10) ? ~data : data;
        npc_in    = (op == 2'b10) ? data : ~data;

        fault = guard_on && (push_like ? (m_depth == SIZE) : (m_depth == 0));
        exp_data = 8'h00;
        if (push_like) begin
            exp_addr = 8'(m_sp);
            if (!fault) begin
                m_mem[m_sp] = data;
                m_sp = (m_sp + 255) % 256;
                m_depth = (m_depth < SIZE) ? m_depth + 1 : SIZE;
            end
        end else begin
            exp_addr = 8'((m_sp + 1) % 256);
            if (!fault) begin
                m_sp = (m_sp + 1) % 256;
                exp_data = m_mem[m_sp];
                m_depth = (m_depth > 0) ? m_depth - 1 : 0;
            end
        end

        @(negedge clk);
        req_valid = 1'b0;
        check("exec req_ready", 32'(req_ready), 32'd0);
        check("exec rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec mem_wr", 32'(mem_wr), 32'(push_like && !fault));
        if (!fault) check("exec mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (push_like && !fault) check("exec mem_wdata", 32'(mem_wdata), 32'(data));

        @(negedge clk);
        rsp_ready = 1'b0;
        check("resp rsp_valid", 32'(rsp_valid), 32'd1);
        check("resp rsp_data", 32'(rsp_data), 32'(exp_data));
        check("resp rsp_is_ret", 32'(rsp_is_ret), 32'(op == 2'b11));
        check("resp rsp_fault", 32'(rsp_fault), 32'(fault));
        check("resp mem_wr", 32'(mem_wr), 32'd0);
        checkFlags("resp");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold rsp_data", 32'(rsp_data), 32'(exp_data));
            check("hold req_ready", 32'(req_ready), 32'd0);
            check("hold mem_wr", 32'(mem_wr), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("after rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " mem_wr"}, 32'(mem_wr), 32'd0);
        checkFlags(tag);
    endtask

    initial begin
`ifdef STACK_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            dmem[i]  = 8'($urandom);
            m_mem[i] = dmem[i];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; push_data = 8'h00;
        npc_in = 8'h00; sp_load = 1'b0; sp_load_val = 8'h00; rsp_ready = 1'b1;
        m_sp = 255; m_depth = 0;

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("reset");
        check("reset mem_addr", 32'(mem_addr), 32'hFF);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of a PUSH's EXEC cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; push_data = 8'hC3;
        @(negedge clk);
        req_valid = 1'b0;
        check("midexec mem_wr before", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midexec reset");
        @(negedge clk);
        rst_n = 1'b1;

        // PUSH/POP and CALL/RET pairs.
        applyStimulus(2'b00, 8'h5A, 0);
        applyStimulus(2'b01, 8'h00, 0);
        applyStimulus(2'b10, 8'h23, 0);
        applyStimulus(2'b11, 8'h00, 0);

        // Backpressure on a POP response.
        applyStimulus(2'b00, 8'h96, 0);
        applyStimulus(2'b01, 8'h00, 5);

        // sp_load wins over a simultaneous request.
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = 8'h80;
        req_valid = 1'b1; req_op = 2'b00; push_data = 8'h11;
        #1 check("spload req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        sp_load = 1'b0; req_valid = 1'b0;
        m_sp = 8'h80; m_depth = 0;
        checkOutput("spload");
        applyStimulus(2'b00, 8'h44, 0);

        // Fill past the STACK_SIZE boundary, then drain past empty.
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = 8'hFF;
        @(negedge clk);
        sp_load = 1'b0;
        m_sp = 255; m_depth = 0;
        for (int i = 0; i < 5; i++) applyStimulus(2'b00, 8'(8'hA0 + i), 0);
        if (guard_on) check("fill sp", 32'(sp_out), 32'hFB);
        else          check("fill sp", 32'(sp_out), 32'hFA);
        check("fill full", 32'(stack_full), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(2'b01, 8'h00, 0);

        // Random operations with random backpressure.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(2'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
